// File: rtl/red_pkg.sv
// rtl/red_pkg.sv - shared constants and types for the rising-edge detector
//
// Purpose:
//   Holds the limits and the output-mode enum used by rising_edge_detector
//   and its synchronizer sub-module.
//
// Contents:
//   MAX_SYNC_STAGES  deepest synchronizer chain the detector accepts
//   ed_mode_e        how ed is produced: combinational or registered
//   ed_mode()        maps the integer REG_OUT parameter onto ed_mode_e

package red_pkg;

  localparam int MAX_SYNC_STAGES = 4;

  typedef enum logic {
    ED_COMB = 1'b0,
    ED_REG  = 1'b1
  } ed_mode_e;

  // Any non-zero REG_OUT selects the registered output.
  function automatic ed_mode_e ed_mode(input int reg_out);
    return (reg_out != 0) ? ED_REG : ED_COMB;
  endfunction

endpackage

// File: rtl/red_sync.sv
// rtl/red_sync.sv - reset-clearable flop chain used as an input synchronizer
//
// Purpose:
//   Delays a WIDTH-bit bus by STAGES clock cycles through a chain of flops.
//   Every stage clears on reset. STAGES=0 is a plain wire.
//
// Ports:
//   clk  input  1      clock, all stages update on its rising edge
//   rst  input  1      synchronous active-high clear of every stage
//   d    input  WIDTH  bus entering the chain
//   q    output WIDTH  bus leaving the last stage (or d when STAGES=0)

module red_sync
  import red_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      // No flops: clk and rst intentionally have no load in this branch.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_chain
      logic [WIDTH-1:0] stage [STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) begin
            stage[i] <= '0;
          end
        end else begin
          stage[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign q = stage[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/rising_edge_detector.sv
// rtl/rising_edge_detector.sv - per-lane 0->1 edge detector with optional sync and output register
//
// Purpose:
//   Produces a one-cycle pulse on ed[i] whenever signal[i] is seen at 1 after
//   having been seen at 0 at the previous clock edge. Optional synchronizer
//   stages sit in front of the detector, and an optional output register
//   trades one cycle of latency for a glitch-free, full-cycle pulse.
//
// Parameters:
//   WIDTH        number of independent lanes (>= 1)
//   SYNC_STAGES  synchronizer flops in front of the detector (0..MAX_SYNC_STAGES)
//   REG_OUT      0 = ed combinational from sampled history, 1 = ed registered
//
// Ports:
//   clk     input  1      single clock
//   rst     input  1      synchronous active-high reset
//   signal  input  WIDTH  level inputs to monitor
//   ed      output WIDTH  rising-edge pulses, active-high

module rising_edge_detector
  import red_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 0,
  parameter int REG_OUT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] signal,
  output logic [WIDTH-1:0] ed
);

  localparam ed_mode_e MODE = ed_mode(REG_OUT);

  generate
    if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
      $error("rising_edge_detector: SYNC_STAGES=%0d outside 0..%0d",
             SYNC_STAGES, MAX_SYNC_STAGES);
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("rising_edge_detector: WIDTH=%0d must be at least 1", WIDTH);
    end
  endgenerate

  // Detector input: either the raw bus or the end of the synchronizer chain.
  logic [WIDTH-1:0] d;

  red_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (signal),
    .q   (d)
  );

  // Value of d captured at the previous edge. Cleared on reset so that an
  // input already high at release produces one edge-out-of-reset pulse.
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
    end else begin
      prev <= d;
    end
  end

  logic [WIDTH-1:0] rise;
  assign rise = d & ~prev;

  generate
    if (MODE == ED_REG) begin : g_reg_out
      logic [WIDTH-1:0] ed_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ed_q <= '0;
        end else begin
          ed_q <= rise;
        end
      end

      // ed_q is already clear after a reset edge, but the gate also kills a
      // pulse in the very cycle rst is raised.
      assign ed = rst ? '0 : ed_q;
    end else begin : g_comb_out
      assign ed = rst ? '0 : rise;
    end
  endgenerate

endmodule

// File: tb/tb_rising_edge_detector.sv
// tb/tb_rising_edge_detector.sv - randomized self-checking bench for rising_edge_detector

module tb_rising_edge_detector;

  localparam int W        = 4;
  localparam int N_DIR    = 15;
  localparam int N_RAND   = 1000;
  localparam int N_TOTAL  = N_DIR + N_RAND;

  logic         clk;
  logic         rst;
  logic [W-1:0] signal;
  logic [W-1:0] ed_a;
  logic [W-1:0] ed_b;
  logic [W-1:0] ed_c;

  int n_checks;
  int n_fails;

  // Per-cycle record of what was applied; entry k is what edge k sampled.
  logic [W-1:0] v [N_TOTAL];
  logic         r [N_TOTAL];

  logic         dir_rst [N_DIR];
  logic [W-1:0] dir_sig [N_DIR];

  rising_edge_detector #(.WIDTH(W), .SYNC_STAGES(0), .REG_OUT(0)) dut_a (
    .clk (clk), .rst (rst), .signal (signal), .ed (ed_a)
  );

  rising_edge_detector #(.WIDTH(W), .SYNC_STAGES(2), .REG_OUT(1)) dut_b (
    .clk (clk), .rst (rst), .signal (signal), .ed (ed_b)
  );

  rising_edge_detector #(.WIDTH(W), .SYNC_STAGES(1), .REG_OUT(0)) dut_c (
    .clk (clk), .rst (rst), .signal (signal), .ed (ed_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Sampled stream seen by the detector at edge k: the input delayed by s
  // edges, forced to 0 if any reset edge lay inside that delay window.
  function automatic logic [W-1:0] seen(input int k, input int s);
    if (k < 0 || k - s < 0) return '0;
    for (int j = k - s; j < k; j++) begin
      if (r[j]) return '0;
    end
    return v[k - s];
  endfunction

  // The value the detector remembers from the edge before k.
  function automatic logic [W-1:0] last_seen(input int k, input int s);
    if (k - 1 < 0 || r[k-1]) return '0;
    return seen(k - 1, s);
  endfunction

  function automatic logic [W-1:0] model_ed(input int k, input int s, input int reg_out);
    if (r[k]) return '0;
    if (reg_out == 0) return seen(k, s) & ~last_seen(k, s);
    if (k - 1 < 0 || r[k-1]) return '0;
    return seen(k - 1, s) & ~last_seen(k - 1, s);
  endfunction

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    signal   = '0;

    dir_rst[0]  = 1'b1; dir_sig[0]  = 4'b0000;
    dir_rst[1]  = 1'b1; dir_sig[1]  = 4'b0000;
    dir_rst[2]  = 1'b0; dir_sig[2]  = 4'b0000;
    dir_rst[3]  = 1'b0; dir_sig[3]  = 4'b0101;
    dir_rst[4]  = 1'b0; dir_sig[4]  = 4'b1111;
    dir_rst[5]  = 1'b0; dir_sig[5]  = 4'b1111;
    dir_rst[6]  = 1'b0; dir_sig[6]  = 4'b0000;
    dir_rst[7]  = 1'b0; dir_sig[7]  = 4'b0000;
    dir_rst[8]  = 1'b1; dir_sig[8]  = 4'b1111;
    dir_rst[9]  = 1'b1; dir_sig[9]  = 4'b1111;
    dir_rst[10] = 1'b0; dir_sig[10] = 4'b1111;
    dir_rst[11] = 1'b0; dir_sig[11] = 4'b1111;
    dir_rst[12] = 1'b0; dir_sig[12] = 4'b0000;
    dir_rst[13] = 1'b1; dir_sig[13] = 4'b0011;
    dir_rst[14] = 1'b0; dir_sig[14] = 4'b0011;

    for (int n = 0; n < N_TOTAL; n++) begin
      @(negedge clk);
      if (n < N_DIR) begin
        rst    = dir_rst[n];
        signal = dir_sig[n];
      end else begin
        rst    = ($urandom_range(0, 49) == 0);
        signal = W'($urandom);
      end
      v[n] = signal;
      r[n] = rst;
      #4;

      check_eq("model_s0_r0", ed_a, model_ed(n, 0, 0));
      check_eq("model_s2_r1", ed_b, model_ed(n, 2, 1));
      check_eq("model_s1_r0", ed_c, model_ed(n, 1, 0));

      case (n)
        0, 1, 2: check_eq("reset_quiet",   ed_a, 4'b0000);
        3:       check_eq("wide_first",    ed_a, 4'b0101);
        4:       check_eq("wide_second",   ed_a, 4'b1010);
        5:       check_eq("held_high",     ed_a, 4'b0000);
        6:       begin
                   check_eq("falling_edge", ed_a, 4'b0000);
                   check_eq("sync_reg_first", ed_b, 4'b0101);
                 end
        7:       check_eq("sync_reg_second", ed_b, 4'b1010);
        8:       begin
                   check_eq("rst_mid_pulse",  ed_a, 4'b0000);
                   check_eq("rst_kills_reg",  ed_b, 4'b0000);
                 end
        10:      check_eq("release_pulse", ed_a, 4'b1111);
        11:      check_eq("release_once",  ed_a, 4'b0000);
        13:      check_eq("rst_on_rise",   ed_a, 4'b0000);
        14:      check_eq("rise_after_rst", ed_a, 4'b0011);
        default: ;
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
